vga_scan_fetch: RTL and testbench
=================================

Name: vga_scan_fetch

Overview:
- Upstream neighbour of the pixel/sync output stage; the master raster timing source for the 640x480 display path.
- Runs the horizontal/vertical scan counters and issues linear read addresses to the framebuffer RAM.
- Delays the counters and the in-frame flag by the RAM read latency, so the output stage receives Horz_Count, Vert_Count, InFrame and colors_data for the same pixel on the same cycle.

Parameters:
- H_ACT, 640, active pixels per line
- HFP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- HBP, 48, horizontal back porch (pixels)
- V_ACT, 480, active lines per frame
- VFP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- VBP, 33, vertical back porch (lines)
- ADDR_W, 19, framebuffer word-address width; must satisfy 2^ADDR_W >= H_ACT*V_ACT
- RD_LATENCY, 2, framebuffer read latency in clocks from rd_en to valid data; legal range 1..4

Ports:
- clock  in  1  system/pixel clock
- reset  in  1  asynchronous, active-high reset
- pix_en  in  1  pixel-rate enable; scan advances only on cycles where pix_en=1
- rd_en  out  1  framebuffer read strobe
- rd_addr  out  ADDR_W  framebuffer linear read address
- Horz_Count  out  32  horizontal position, delayed by RD_LATENCY
- Vert_Count  out  32  vertical position, delayed by RD_LATENCY
- InFrame  out  1  active-region flag, delayed by RD_LATENCY
- frame_start  out  1  one-clock pulse when the fetch side enters pixel (0,0)
- frame_count  out  16  frames completed since reset; wraps

Behaviour:
- Totals: H_TOT = H_ACT+HFP+H_SYNC+HBP (800); V_TOT = V_ACT+VFP+V_SYNC+VBP (525).
- Reset (asynchronous assert, release on clock edge): internal h=0, v=0, addr=0; every delay stage cleared. All outputs read 0: rd_en, rd_addr, Horz_Count, Vert_Count, InFrame, frame_start, frame_count.
- First scan position after reset release is (0,0).
- Scan counters, advancing only when pix_en=1:
  - h increments by 1.
  - At h==H_TOT-1: h<=0 and v increments.
  - At h==H_TOT-1 and v==V_TOT-1: v<=0 and frame_count increments, wrapping 0xFFFF->0.
  - pix_en=0: every scan register holds.
- Fetch, registered one clock behind the scan counters:
  - rd_en=1 exactly when h<H_ACT and v<V_ACT, and only on clocks where pix_en=1. No extra reads when pix_en=0.
  - rd_addr is a linear counter. It presents the current value with each rd_en, then increments after it, so the sequence is 0,1,...,H_ACT*V_ACT-1.
  - It resets to 0 at h==0 and v==0, so rd_addr always equals v*H_ACT+h. No multiplier is permitted.
  - frame_start = 1 on the clock rd_en is issued for (0,0).
- Alignment pipeline:
  - (h, v, active) are captured alongside rd_en and shifted through RD_LATENCY register stages every clock, independent of pix_en.
  - Horz_Count/Vert_Count are zero-extended to 32 bits.
  - Result: total delay of Horz_Count/Vert_Count/InFrame relative to rd_en is RD_LATENCY clocks, identical to the RAM data delay.
  - InFrame is 1 only for active pixels; porches and sync give 0.
- Ranges: Horz_Count spans 0..H_TOT-1 and Vert_Count spans 0..V_TOT-1, as required by the downstream sync compare (sync active for count > ACT+FP and <= ACT+FP+SYNC).
- Reset mid-frame: every stage clears in the same clock. The next scan restarts at (0,0) with rd_addr 0, and no stale InFrame is emitted after release.
- pix_en toggling mid-line: no pixel is skipped or repeated, and rd_addr remains equal to v*H_ACT+h at every read.

Test Plan:
- Reset then pix_en=1 constant, RD_LATENCY=2 -> rd_en rises on the 2nd clock after reset release with rd_addr=0 and frame_start=1. Horz_Count=0, Vert_Count=0, InFrame=1 appear 2 clocks after that rd_en.
- Run one full line -> exactly 640 rd_en pulses with addresses 0..639. InFrame low for Horz_Count 640..799. Line 1 starts at rd_addr=640.
- Run a full frame -> 307200 reads, last rd_addr=307199. Vert_Count reaches 524 then wraps to 0. frame_count 0->1. frame_start pulses once per 420000 pix_en cycles.
- pix_en asserted every 2nd clock (clock = 2x pixel rate) -> same address sequence as the previous scenario. Each position is held 2 clocks. rd_en never asserted on pix_en=0 cycles.
- Assert reset at h=300, v=200 for 3 clocks -> all outputs 0 immediately (asynchronous). After release the sequence restarts at (0,0), rd_addr=0, with no InFrame=1 leaking from the pre-reset pipeline.
- Parameter sweep RD_LATENCY=1 and 4 -> model RAM returns data equal to its address. Check colors_data == Horz_Count+640*Vert_Count whenever InFrame=1.

Source files
------------

// File: rtl/vga_scan_fetch.sv
// rtl/vga_scan_fetch.sv - raster scan counters, framebuffer read fetch and latency-matched position pipeline
module vga_scan_fetch #(
  parameter int H_ACT      = 640,
  parameter int HFP        = 16,
  parameter int H_SYNC     = 96,
  parameter int HBP        = 48,
  parameter int V_ACT      = 480,
  parameter int VFP        = 10,
  parameter int V_SYNC     = 2,
  parameter int VBP        = 33,
  parameter int ADDR_W     = 19,
  parameter int RD_LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              pix_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic [31:0]       Horz_Count,
  output logic [31:0]       Vert_Count,
  output logic              InFrame,
  output logic              frame_start,
  output logic [15:0]       frame_count
);

  localparam int H_TOT = H_ACT + HFP + H_SYNC + HBP;
  localparam int V_TOT = V_ACT + VFP + V_SYNC + VBP;
  localparam int HW    = $clog2(H_TOT);
  localparam int VW    = $clog2(V_TOT);

  localparam logic [HW-1:0] H_LAST  = HW'(H_TOT - 1);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOT - 1);
  localparam logic [HW-1:0] H_ACT_C = HW'(H_ACT);
  localparam logic [VW-1:0] V_ACT_C = VW'(V_ACT);

  // Scan state
  logic [HW-1:0]     h_q, h_d;
  logic [VW-1:0]     v_q, v_d;
  logic [15:0]       fc_q, fc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  // Fetch stage
  logic              rd_en_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              fs_q;

  // Position pipeline: stage 0 sits beside rd_en, stage RD_LATENCY meets the RAM data
  logic [HW-1:0] hp_q [RD_LATENCY+1];
  logic [VW-1:0] vp_q [RD_LATENCY+1];
  logic          ap_q [RD_LATENCY+1];

  logic              active;
  logic              at_origin;
  logic [ADDR_W-1:0] addr_cur;

  // Next scan position, frame counter and linear address; everything holds without pix_en
  always_comb begin
    h_d       = h_q;
    v_d       = v_q;
    fc_d      = fc_q;
    addr_d    = addr_q;
    active    = (h_q < H_ACT_C) && (v_q < V_ACT_C);
    at_origin = (h_q == '0) && (v_q == '0);
    // Re-anchoring at the origin keeps the address equal to v*H_ACT+h without a multiplier
    addr_cur  = at_origin ? '0 : addr_q;
    if (pix_en) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        if (v_q == V_LAST) begin
          v_d  = '0;
          fc_d = fc_q + 16'd1;
        end else begin
          v_d = v_q + VW'(1);
        end
      end else begin
        h_d = h_q + HW'(1);
      end
      if (active) begin
        addr_d = addr_cur + ADDR_W'(1);
      end
    end
  end

  // Scan register update
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      h_q    <= '0;
      v_q    <= '0;
      fc_q   <= '0;
      addr_q <= '0;
    end else begin
      h_q    <= h_d;
      v_q    <= v_d;
      fc_q   <= fc_d;
      addr_q <= addr_d;
    end
  end

  // Issue one read per active pixel step and mark the origin pixel
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      fs_q      <= 1'b0;
    end else begin
      rd_en_q <= pix_en & active;
      fs_q    <= pix_en & at_origin;
      if (pix_en && active) begin
        rd_addr_q <= addr_cur;
      end
    end
  end

  // Capture the position with each pixel step, then shift it every clock to track RAM latency
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i <= RD_LATENCY; i++) begin
        hp_q[i] <= '0;
        vp_q[i] <= '0;
        ap_q[i] <= 1'b0;
      end
    end else begin
      if (pix_en) begin
        hp_q[0] <= h_q;
        vp_q[0] <= v_q;
        ap_q[0] <= active;
      end
      for (int i = 1; i <= RD_LATENCY; i++) begin
        hp_q[i] <= hp_q[i-1];
        vp_q[i] <= vp_q[i-1];
        ap_q[i] <= ap_q[i-1];
      end
    end
  end

  assign rd_en       = rd_en_q;
  assign rd_addr     = rd_addr_q;
  assign frame_start = fs_q;
  assign frame_count = fc_q;
  assign Horz_Count  = 32'(hp_q[RD_LATENCY]);
  assign Vert_Count  = 32'(vp_q[RD_LATENCY]);
  assign InFrame     = ap_q[RD_LATENCY];

endmodule

// File: tb/tb_vga_scan_fetch.sv
// tb/tb_vga_scan_fetch.sv - scoreboard bench for vga_scan_fetch over three read latencies
module tb_vga_scan_fetch;

  localparam int HA  = 16;
  localparam int HFP = 2;
  localparam int HS  = 3;
  localparam int HBP = 3;
  localparam int VA  = 6;
  localparam int VFP = 1;
  localparam int VS  = 1;
  localparam int VBP = 2;
  localparam int AW  = 8;
  localparam int HT  = HA + HFP + HS + HBP;
  localparam int VT  = VA + VFP + VS + VBP;
  localparam int FT  = HT * VT;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          fs;
  } rd_t;

  typedef struct packed {
    logic [15:0] h;
    logic [15:0] v;
  } px_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic pix_en = 1'b0;
  logic done = 1'b0;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  task automatic chk(input bit ok, input string nm, input longint act, input longint exp);
    checks++;
    if (!ok) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_lat
    localparam int L = (g == 0) ? 1 : (g == 1) ? 2 : 4;

    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [31:0]   hc;
    logic [31:0]   vc;
    logic          inf;
    logic          fs;
    logic [15:0]   fc;

    vga_scan_fetch #(
      .H_ACT(HA), .HFP(HFP), .H_SYNC(HS), .HBP(HBP),
      .V_ACT(VA), .VFP(VFP), .V_SYNC(VS), .VBP(VBP),
      .ADDR_W(AW), .RD_LATENCY(L)
    ) u_dut (
      .clock(clk), .reset(rst), .pix_en(pix_en),
      .rd_en(rd_en), .rd_addr(rd_addr),
      .Horz_Count(hc), .Vert_Count(vc), .InFrame(inf),
      .frame_start(fs), .frame_count(fc)
    );

    // Framebuffer model: data equals the address, L clocks after rd_en, held between reads
    logic [AW-1:0] ram_q [L];
    always @(posedge clk) begin
      if (rd_en) ram_q[0] <= rd_addr;
      for (int i = 1; i < L; i++) ram_q[i] <= ram_q[i-1];
    end

    // Marks the cycle on which a new pixel reaches the output
    logic [L:0] pe_d;
    always @(posedge clk or posedge rst) begin
      if (rst) pe_d <= '0;
      else     pe_d <= {pe_d[L-1:0], pix_en};
    end

    rd_t    q_rd[$];
    px_t    q_px[$];
    longint n = 0;

    // Reference model: pixel step number n fixes the raster position by division
    always @(posedge clk) begin
      int h, v;
      if (rst) begin
        n = 0;
      end else if (pix_en) begin
        h = int'(n % HT);
        v = int'((n / HT) % VT);
        q_px.push_back('{h: 16'(h), v: 16'(v)});
        if (h < HA && v < VA) q_rd.push_back('{addr: AW'(v * HA + h), fs: (h == 0 && v == 0)});
        n = n + 1;
      end
    end

    // Outputs read zero as soon as reset is asserted
    always @(posedge rst) begin
      #1;
      chk(rd_en == 1'b0, $sformatf("L%0d rst rd_en", L), rd_en, 0);
      chk(rd_addr == '0, $sformatf("L%0d rst rd_addr", L), rd_addr, 0);
      chk(hc == 32'd0, $sformatf("L%0d rst Horz_Count", L), hc, 0);
      chk(vc == 32'd0, $sformatf("L%0d rst Vert_Count", L), vc, 0);
      chk(inf == 1'b0, $sformatf("L%0d rst InFrame", L), inf, 0);
      chk(fs == 1'b0, $sformatf("L%0d rst frame_start", L), fs, 0);
      chk(fc == 16'd0, $sformatf("L%0d rst frame_count", L), fc, 0);
    end

    // Monitor
    logic [15:0] last_h = '0;
    logic        last_inf = 1'b0;
    always @(negedge clk) begin
      rd_t e;
      px_t p;
      bit  ei;
      if (rst) begin
        q_rd.delete();
        q_px.delete();
        last_h   = '0;
        last_inf = 1'b0;
      end else begin
        chk(fc == 16'(n / FT), $sformatf("L%0d frame_count", L), fc, (n / FT) % 65536);
        if (rd_en) begin
          if (q_rd.size() == 0) begin
            chk(1'b0, $sformatf("L%0d rd_en unexpected", L), rd_addr, -1);
          end else begin
            e = q_rd.pop_front();
            chk(rd_addr == e.addr, $sformatf("L%0d rd_addr", L), rd_addr, e.addr);
            chk(fs == e.fs, $sformatf("L%0d frame_start", L), fs, e.fs);
          end
        end else begin
          chk(fs == 1'b0, $sformatf("L%0d frame_start idle", L), fs, 0);
        end
        if (pe_d[L]) begin
          if (q_px.size() == 0) begin
            chk(1'b0, $sformatf("L%0d pixel unexpected", L), hc, -1);
          end else begin
            p  = q_px.pop_front();
            ei = (p.h < HA) && (p.v < VA);
            chk(hc == 32'(p.h), $sformatf("L%0d Horz_Count", L), hc, p.h);
            chk(vc == 32'(p.v), $sformatf("L%0d Vert_Count", L), vc, p.v);
            chk(inf == ei, $sformatf("L%0d InFrame", L), inf, ei);
            if (ei) chk(longint'(ram_q[L-1]) == longint'(p.h) + HA * longint'(p.v),
                        $sformatf("L%0d colors_data", L), ram_q[L-1], p.h + HA * p.v);
            last_h   = p.h;
            last_inf = ei;
          end
        end else begin
          chk(hc == 32'(last_h), $sformatf("L%0d Horz_Count hold", L), hc, last_h);
          chk(inf == last_inf, $sformatf("L%0d InFrame hold", L), inf, last_inf);
        end
      end
    end

    // Every issued read and pixel must have come out by the end
    always @(posedge done) begin
      chk(q_rd.size() == 0, $sformatf("L%0d reads left", L), q_rd.size(), 0);
      chk(q_px.size() == 0, $sformatf("L%0d pixels left", L), q_px.size(), 0);
    end
  end

  task automatic run(input int cycles, input int mode);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      case (mode)
        0:       pix_en = 1'b0;
        1:       pix_en = 1'b1;
        2:       pix_en = (i % 2) == 0;
        default: pix_en = 1'($urandom_range(0, 1));
      endcase
    end
  endtask

  initial begin
    #2 rst = 1'b1;
    run(3, 0);
    @(negedge clk);
    #1 rst = 1'b0;
    run(2 * FT + 40, 1);
    run(4 * FT, 2);
    run(3 * FT, 3);
    run(FT + 130, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    run(3, 1);
    @(negedge clk);
    #1 rst = 1'b0;
    run(FT + 60, 1);
    run(FT, 3);
    run(12, 0);
    @(negedge clk);
    done = 1'b1;
    #1;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
